// File: rtl/serial_pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_pkg
//  Purpose  : Shared types and helpers for the serial pattern transmitter.
//             Holds the FSM state encoding and the counter-width helper
//             used by the interface, the top level and the shift register.
//  Revision : 1.0  initial release
// ============================================================================
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // A counter must be at least one bit wide even when its maximum is 0.
    localparam int c_MIN_CNT_W = 1;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < c_MIN_CNT_W) ? c_MIN_CNT_W : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx_if
//  Purpose  : Start/ready request bus and serial output bundle of the
//             serial pattern transmitter.
//  Ports    : start_i, data_i[WIDTH], len_i[clog2(WIDTH+1)]  requester -> tx
//             ready_o, bit_o, bit_valid_o, last_o, done_o     tx -> requester
//             master = requester/receiver side, slave = transmitter side.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_pattern_tx_if
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int c_LEN_W = cnt_width(WIDTH);

    logic               start_i;
    logic [WIDTH-1:0]   data_i;
    logic [c_LEN_W-1:0] len_i;
    logic               ready_o;
    logic               bit_o;
    logic               bit_valid_o;
    logic               last_o;
    logic               done_o;

    modport master (
        output start_i, data_i, len_i,
        input  ready_o, bit_o, bit_valid_o, last_o, done_o
    );

    modport slave (
        input  start_i, data_i, len_i,
        output ready_o, bit_o, bit_valid_o, last_o, done_o
    );

endinterface
`default_nettype wire

// File: rtl/serial_pattern_tx_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_shift_reg
//  Purpose  : Parallel-load shift register with selectable direction.
//             o_bit_next is the head bit the register will hold after this
//             clock edge, so the owner can register it as its serial output
//             and have the first bit appear the cycle after the load.
//  Ports    : clk, rst_n (async, active-low)
//             i_load  - capture i_data (aligned for i_len when MSB first)
//             i_shift - advance by one bit towards the head
//             i_data, i_len - parallel pattern and its length (1..WIDTH)
//             o_bit_next    - next head bit
//  Revision : 1.0  initial release
// ============================================================================
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int LEN_W     = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic [LEN_W-1:0] i_len,
    output logic                  o_bit_next
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_next;

    always_comb begin
        w_sr_next = r_sr;
        if (i_load) begin
            // MSB first: move data[len-1] up to the head at bit WIDTH-1 so
            // the shift always leaves from the same end whatever the length.
            if (MSB_FIRST != 0) begin
                w_sr_next = i_data << (LEN_W'(WIDTH) - i_len);
            end else begin
                w_sr_next = i_data;
            end
        end else if (i_shift) begin
            if (MSB_FIRST != 0) begin
                w_sr_next = {r_sr[WIDTH-2:0], 1'b0};
            end else begin
                w_sr_next = {1'b0, r_sr[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_bit_next = (MSB_FIRST != 0) ? w_sr_next[WIDTH-1] : w_sr_next[0];

endmodule
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx
//  Purpose  : Serial bit-stream transmitter. Accepts a pattern and a length
//             on a start/ready handshake, shifts it out one bit per clock
//             with valid/last flags, idles for GAP_CYCLES, pulses done.
//  Ports    : clk_i  - clock, rising edge
//             rst_ni - asynchronous active-low reset
//             bus    - serial_pattern_tx_if.slave (start/data/len in,
//                      ready/bit/bit_valid/last/done out, all registered)
//  Revision : 1.0  initial release
// ============================================================================
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    serial_pattern_tx_if.slave bus
);

    localparam int c_LEN_W = cnt_width(WIDTH);
    localparam int c_GAP_W = cnt_width(GAP_CYCLES);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_LEN_W-1:0] r_bit_cnt;
    logic [c_LEN_W-1:0] w_bit_cnt_next;
    logic [c_LEN_W-1:0] w_len_sat;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_next;

    logic r_ready, r_bit, r_valid, r_last, r_done;
    logic w_ready_next, w_bit_next, w_valid_next, w_last_next, w_done_next;
    logic w_load, w_shift, w_sr_bit_next;

    assign w_len_sat = (bus.len_i > c_LEN_W'(WIDTH)) ? c_LEN_W'(WIDTH) : bus.len_i;

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .LEN_W     (c_LEN_W)
    ) u_shift_reg (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (bus.data_i),
        .i_len      (w_len_sat),
        .o_bit_next (w_sr_bit_next)
    );

    // r_bit_cnt holds the bits still to be shown, including the one on
    // bit_o in the current SHIFT cycle; the value 1 marks the final bit.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_ready_next   = 1'b0;
        w_valid_next   = 1'b0;
        w_last_next    = 1'b0;
        w_done_next    = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_i && (bus.len_i != '0)) begin
                    w_load         = 1'b1;
                    w_bit_cnt_next = w_len_sat;
                    w_state_next   = ST_SHIFT;
                    w_valid_next   = 1'b1;
                    w_last_next    = (w_len_sat == c_LEN_W'(1));
                end else begin
                    w_ready_next   = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (r_bit_cnt <= c_LEN_W'(1)) begin
                    w_bit_cnt_next = '0;
                    w_done_next    = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_state_next   = ST_GAP;
                        w_gap_cnt_next = c_GAP_W'(GAP_CYCLES);
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_ready_next   = 1'b1;
                    end
                end else begin
                    w_shift        = 1'b1;
                    w_bit_cnt_next = r_bit_cnt - c_LEN_W'(1);
                    w_valid_next   = 1'b1;
                    w_last_next    = (r_bit_cnt == c_LEN_W'(2));
                end
            end

            ST_GAP: begin
                if (r_gap_cnt <= c_GAP_W'(1)) begin
                    w_gap_cnt_next = '0;
                    w_state_next   = ST_IDLE;
                    w_ready_next   = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - c_GAP_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_ready_next = 1'b1;
            end
        endcase

        w_bit_next = w_valid_next ? w_sr_bit_next : IDLE_BIT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b1;
            r_bit     <= IDLE_BIT;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_ready   <= w_ready_next;
            r_bit     <= w_bit_next;
            r_valid   <= w_valid_next;
            r_last    <= w_last_next;
            r_done    <= w_done_next;
        end
    end

    assign bus.ready_o     = r_ready;
    assign bus.bit_o       = r_bit;
    assign bus.bit_valid_o = r_valid;
    assign bus.last_o      = r_last;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-stream transmitter that drives the single-bit `in1`-style input of the team's serial FSM exercise blocks (sequence detectors / Moore-Mealy machines).
- Accepts a parallel pattern plus a length through a start/ready handshake.
- Shifts the pattern out one bit per clock with a valid flag and a last-bit flag, inserts a programmable idle gap, then pulses done.
- Used by exercise top levels and benches so that stimulus no longer has to be hand-timed.

Parameters:
- WIDTH, 8, maximum pattern length in bits (>= 2).
- MSB_FIRST, 1, 1 = send data[len-1] first down to data[0]; 0 = send data[0] first up to data[len-1].
- GAP_CYCLES, 1, idle cycles inserted after each frame before ready_o reasserts (0 allowed).
- IDLE_BIT, 0, level driven on bit_o whenever bit_valid_o=0.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request to transmit; accepted only when ready_o=1.
- data_i  in  WIDTH  pattern, sampled on acceptance.
- len_i  in  $clog2(WIDTH+1)  number of bits to send, sampled on acceptance.
- ready_o  out  1  block idle and able to accept start_i.
- bit_o  out  1  serial data; connects to a receiver's in1.
- bit_valid_o  out  1  bit_o carries a pattern bit this cycle.
- last_o  out  1  current bit is the final bit of the frame.
- done_o  out  1  one-cycle pulse after a frame completes.

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: ready_o=1, bit_o=IDLE_BIT, bit_valid_o=0, last_o=0, done_o=0. State is IDLE, the counters are 0 and the shift register is 0.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously). The frame is abandoned and done_o is not pulsed.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready_o=1.
  - Acceptance condition: start_i=1 and len_i!=0.
  - On acceptance: capture data_i into the shift register and min(len_i, WIDTH) into the bit counter, then go to SHIFT. ready_o drops in the following cycle.
  - start_i with len_i=0: ignored. The block stays in IDLE, no done_o pulse.
  - len_i>WIDTH: saturates to WIDTH.
- SHIFT:
  - The first bit appears on bit_o with bit_valid_o=1 in the cycle after acceptance (latency 1).
  - One bit per cycle, with no stalls.
  - Bit order:
    - MSB_FIRST=1 sends data[len-1] first down to data[0].
    - MSB_FIRST=0 sends data[0] first up to data[len-1].
    - Bits above len-1 are never sent.
  - last_o=1 together with the final bit only.
  - start_i is ignored during SHIFT and GAP.
  - After the final bit: go to GAP if GAP_CYCLES>0, otherwise to IDLE.
- Frame end:
  - done_o=1 for exactly the one cycle after the final bit, which is the first GAP or IDLE cycle.
  - bit_valid_o=0 and bit_o=IDLE_BIT from that cycle on.
- GAP:
  - Lasts exactly GAP_CYCLES cycles, counted from the cycle after the final bit, with ready_o=0.
  - Then go to IDLE; ready_o=1 in the next cycle.
  - With GAP_CYCLES=0, ready_o=1 in the same cycle as done_o, and a new start is accepted there. Back-to-back frames then have a 1-cycle bubble (bit_valid_o=0).
- Frame length: a frame of L bits occupies bit_valid_o for exactly L consecutive cycles. Start acceptance to the next ready_o takes L+GAP_CYCLES+1 cycles.
- Counter widths: $clog2(WIDTH+1) for the bit count and $clog2(GAP_CYCLES+1) for the gap. The counters do not wrap; they stop at 0.

Decomposition:
- Package serial_tx_pkg holds:
  - the state enum (IDLE, SHIFT, GAP) typedef;
  - the localparam for the length width function.
- One natural sub-module, serial_shift_reg: a parallel-load shift register with a direction parameter, a load/shift enable and a serial out.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Reset then idle: hold rst_ni=0 for 2 cycles, then release -> ready_o=1, bit_o=0, bit_valid_o=0, done_o=0 for 5 idle cycles.
- MSB-first frame: data_i=8'b1011_0010, len_i=8, start for 1 cycle -> bit_o = 1,0,1,1,0,0,1,0 on the 8 cycles after acceptance. last_o is high on the 8th bit only; done_o pulses 1 cycle later; ready_o returns after GAP_CYCLES=1.
- Short LSB-first frame: MSB_FIRST=0, data_i=8'hFA, len_i=3 -> bits 0,1,0, then bit_valid_o=0. The upper bits are never driven.
- Boundary lengths:
  - len_i=0 with start -> no state change, ready_o stays 1, no done_o.
  - len_i=15 (exceeds WIDTH=8) -> exactly 8 bits sent.
- Ignored start and back-to-back frames:
  - start_i held high through a frame -> no restart mid-frame.
  - GAP_CYCLES=0 with start held -> second frame accepted on the done_o cycle, with exactly one bubble cycle between frames.
- Reset mid-frame: drop rst_ni after 3 of 8 bits -> outputs at reset values immediately, no done_o. The next frame transmits correctly from bit 0.
